// File: rtl/lsu_mem_if.sv
// Load/store unit between decode/ALU and a word-addressed data RAM with a req/ack handshake.
// Holds the core in stall while an access is outstanding and presents extended load data for one cycle.
module lsu_mem_if #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_wr_en,
    input  logic              d_rd_en,
    input  logic [1:0]        store_size,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              uns_q, uns_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req;
    logic              is_store;
    logic [1:0]        req_size;
    logic              aligned;
    logic [3:0]        req_be;
    logic [31:0]       req_wdata;
    logic              take;
    logic              ack_exit;
    logic              timeout_exit;

    // Sign/zero-extend the addressed byte or halfword of a RAM word.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (size)
            SZ_BYTE: extract_load = {{24{~uns & b[7]}}, b};
            SZ_HALF: extract_load = {{16{~uns & h[15]}}, h};
            default: extract_load = word;
        endcase
    endfunction

    assign req      = d_wr_en | d_rd_en;
    assign is_store = d_wr_en;
    assign req_size = is_store ? store_size : load_size;

    always_comb begin
        case (req_size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Per-lane byte enable and store-data replication.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign req_be[gi] = (req_size == SZ_BYTE) ? (addr[1:0] == 2'(gi)) :
                            (req_size == SZ_HALF) ? (addr[1] == 1'(gi / 2)) :
                                                    1'b1;
        assign req_wdata[8*gi +: 8] = (req_size == SZ_BYTE) ? wdata[7:0] :
                                      (req_size == SZ_HALF) ? wdata[8*(gi % 2) +: 8] :
                                                              wdata[8*gi +: 8];
    end

    assign take         = (state_q == S_IDLE) & req & aligned;
    assign ack_exit     = (state_q == S_ACCESS) & mem_ack;
    assign timeout_exit = (state_q == S_ACCESS) & ~mem_ack & (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (take) state_d = S_ACCESS;
            S_ACCESS: if (ack_exit || timeout_exit) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        bus_err    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;
        rdata      = '0;
        // Keep the combinational request responses quiet while reset is held.
        if (!reset) begin
            case (state_q)
                S_IDLE: begin
                    stall      = req & aligned;
                    misaligned = req & ~aligned;
                end
                S_ACCESS: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_be    = be_q;
                    mem_wdata = wdata_q;
                end
                S_DONE: begin
                    rdata   = rdata_q;
                    bus_err = err_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        off_d   = off_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (take) begin
            we_d    = is_store;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = req_be;
            wdata_d = is_store ? req_wdata : 32'd0;
            size_d  = req_size;
            off_d   = addr[1:0];
            uns_d   = load_unsigned;
        end
        if (state_q == S_ACCESS) begin
            cnt_d = (ack_exit || timeout_exit) ? '0 : cnt_q + 1'b1;
        end
        if (ack_exit) begin
            rdata_d = we_q ? 32'd0 : extract_load(mem_rdata, size_q, off_q, uns_q);
            err_d   = 1'b0;
        end else if (timeout_exit) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: a transaction-level model predicts every output each cycle,
// and hand-computed literals pin the key results of each access.
module tb_lsu_mem_if;

    localparam int TIMEOUT = 16;
    localparam int ADDR_W  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_wr_en = 1'b0;
    logic        d_rd_en = 1'b0;
    logic [1:0]  store_size = 2'b00;
    logic [1:0]  load_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        stall;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu_mem_if #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .d_wr_en(d_wr_en), .d_rd_en(d_rd_en),
        .store_size(store_size), .load_size(load_size), .load_unsigned(load_unsigned),
        .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b1;

    // Expected outputs for the current cycle.
    logic [31:0] e_rdata = '0, e_mem_addr = '0, e_mem_wdata = '0;
    logic [3:0]  e_be = '0;
    logic        e_stall = 0, e_mis = 0, e_err = 0, e_req = 0, e_we = 0;

    // Observations gathered over one transaction.
    int          o_stall, o_mis, o_err, o_req, o_unstable;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic        o_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", 32'(stall), 32'(e_stall));
            check("misaligned", 32'(misaligned), 32'(e_mis));
            check("bus_err", 32'(bus_err), 32'(e_err));
            check("mem_req", 32'(mem_req), 32'(e_req));
            check("mem_we", 32'(mem_we), 32'(e_we));
            check("mem_addr", mem_addr, e_mem_addr);
            check("mem_be", 32'(mem_be), 32'(e_be));
            check("mem_wdata", mem_wdata, e_mem_wdata);
            check("rdata", rdata, e_rdata);
        end
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int lane = int'(a % 4);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) if (i >= lane && i < lane + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [31:0] a, input bit uns);
        int n = nbytes(sz);
        int lane = int'(a % 4);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(lane + i) +: 8];
        if (!uns && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
        return v[31:0];
    endfunction

    task automatic exp_idle();
        e_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0; e_be = '0;
        e_stall = 0; e_mis = 0; e_err = 0; e_req = 0; e_we = 0;
    endtask

    task automatic drop_inputs();
        d_wr_en = 0; d_rd_en = 0; addr = '0; wdata = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    task automatic observe(input bit is_done);
        @(negedge clk); #1;
        if (stall) o_stall++;
        if (misaligned) o_mis++;
        if (bus_err) o_err++;
        if (mem_req) begin
            if (o_req == 0) begin
                o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
            end else if (mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wdata || mem_we !== o_we) begin
                o_unstable++;
            end
            o_req++;
        end
        if (is_done) o_rdata = rdata;
    endtask

    // ack_at: ACCESS cycle (1-based) carrying mem_ack; 0 means never (timeout).
    task automatic access(input string name, input bit wr, input bit rd,
                          input logic [1:0] ssz, input logic [1:0] lsz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rword, input bit late_ack);
        logic [1:0] sz = wr ? ssz : lsz;
        bit tmo = (ack_at < 1 || ack_at > TIMEOUT);
        int k = tmo ? TIMEOUT : ack_at;
        o_stall = 0; o_mis = 0; o_err = 0; o_req = 0; o_unstable = 0;
        o_be = '0; o_addr = '0; o_wdata = '0; o_rdata = '0; o_we = 0;

        @(posedge clk); #1;
        d_wr_en = wr; d_rd_en = rd; store_size = ssz; load_size = lsz;
        load_unsigned = uns; addr = a; wdata = wd; mem_ack = 0; mem_rdata = 32'hA5A5_5A5A;
        exp_idle();
        if (!m_aligned(sz, a)) begin
            e_mis = 1;
            observe(0);
            @(posedge clk); #1;
            drop_inputs(); exp_idle();
            observe(0);
        end else begin
            e_stall = 1;
            observe(0);
            for (int i = 1; i <= k; i++) begin
                @(posedge clk); #1;
                mem_ack   = !tmo && (i == k);
                mem_rdata = mem_ack ? rword : 32'hA5A5_5A5A;
                exp_idle();
                e_stall = 1; e_req = 1; e_we = wr;
                e_mem_addr  = a - (a % 4);
                e_be        = m_be(sz, a);
                e_mem_wdata = wr ? m_wdata(sz, wd) : 32'd0;
                observe(0);
            end
            @(posedge clk); #1;
            mem_ack = 0; mem_rdata = 32'hA5A5_5A5A;
            exp_idle();
            e_err   = tmo;
            e_rdata = (tmo || wr) ? 32'd0 : m_load(rword, sz, a, uns);
            observe(1);
            @(posedge clk); #1;
            drop_inputs(); mem_ack = late_ack; exp_idle();
            observe(0);
            if (late_ack) begin
                @(posedge clk); #1;
                mem_ack = 0; exp_idle();
                observe(0);
            end
        end
        $display("[TB] %s addr=0x%08h stall_cycles=%0d req_cycles=%0d be=%b rdata=0x%08h mis=%0d err=%0d",
                 name, a, o_stall, o_req, o_be, o_rdata, o_mis, o_err);
    endtask

    initial begin
        // Pin the model against hand-computed values.
        check("pin_model_lb", m_load(32'h0080_0000, 2'b00, 32'h2002, 0), 32'hFFFF_FF80);
        check("pin_model_lh", m_load(32'h7FFF_0000, 2'b01, 32'h5002, 0), 32'h0000_7FFF);
        check("pin_model_be", 32'(m_be(2'b00, 32'h1003)), 32'h8);

        exp_idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_req", 32'(mem_req), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        reset = 0;

        access("sb", 1, 0, 2'b00, 2'b00, 0, 32'h1003, 32'h0000_00AB, 1, 32'h0, 0);
        check("sb_be", 32'(o_be), 32'h8);
        check("sb_wdata", o_wdata, 32'hABAB_ABAB);
        check("sb_addr", o_addr, 32'h1000);
        check("sb_stall_cycles", o_stall, 2);
        check("sb_we", 32'(o_we), 32'd1);

        access("lb", 0, 1, 2'b00, 2'b00, 0, 32'h2002, 32'h0, 2, 32'h0080_0000, 0);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        access("lbu", 0, 1, 2'b00, 2'b00, 1, 32'h2002, 32'h0, 2, 32'h0080_0000, 0);
        check("lbu_rdata", o_rdata, 32'h0000_0080);

        access("lw_slow", 0, 1, 2'b00, 2'b10, 0, 32'h3000, 32'h0, 5, 32'hDEAD_BEEF, 0);
        check("lw_stall_cycles", o_stall, 6);
        check("lw_rdata", o_rdata, 32'hDEAD_BEEF);
        check("lw_req_cycles", o_req, 5);
        check("lw_req_stable", o_unstable, 0);

        access("sw_misaligned", 1, 0, 2'b10, 2'b00, 0, 32'h4002, 32'h1122_3344, 1, 32'h0, 0);
        check("mis_pulses", o_mis, 1);
        check("mis_req_cycles", o_req, 0);
        check("mis_stall_cycles", o_stall, 0);

        access("lw_timeout", 0, 1, 2'b00, 2'b10, 0, 32'h6000, 32'h0, 0, 32'h1234_5678, 1);
        check("tmo_err_pulses", o_err, 1);
        check("tmo_req_cycles", o_req, TIMEOUT);
        check("tmo_rdata", o_rdata, 32'h0);
        check("tmo_stall_cycles", o_stall, TIMEOUT + 1);

        access("sh", 1, 0, 2'b01, 2'b00, 0, 32'h1002, 32'h1234_BEEF, 3, 32'h0, 0);
        check("sh_be", 32'(o_be), 32'hC);
        check("sh_wdata", o_wdata, 32'hBEEF_BEEF);

        access("lh_neg", 0, 1, 2'b00, 2'b01, 0, 32'h0010, 32'h0, 1, 32'h1234_8001, 0);
        check("lh_neg_rdata", o_rdata, 32'hFFFF_8001);

        access("st_ld_both", 1, 1, 2'b10, 2'b00, 0, 32'h0020, 32'hCAFE_F00D, 2, 32'h9999_9999, 0);
        check("both_we", 32'(o_we), 32'd1);
        check("both_rdata", o_rdata, 32'h0);

        access("lh_misaligned", 0, 1, 2'b00, 2'b01, 0, 32'h7001, 32'h0, 1, 32'h0, 0);
        check("lh_mis_pulses", o_mis, 1);

        access("sw_size3", 1, 0, 2'b11, 2'b00, 0, 32'h0024, 32'h0102_0304, 1, 32'h0, 0);
        check("sz3_be", 32'(o_be), 32'hF);
        access("lw_size3", 0, 1, 2'b00, 2'b11, 0, 32'h0028, 32'h0, 1, 32'h8765_4321, 0);
        check("lz3_rdata", o_rdata, 32'h8765_4321);

        // Reset asserted in the middle of an outstanding load.
        @(posedge clk); #1;
        d_rd_en = 1; load_size = 2'b10; load_unsigned = 0; addr = 32'h3100;
        exp_idle(); e_stall = 1;
        @(posedge clk); #1;
        exp_idle(); e_stall = 1; e_req = 1; e_mem_addr = 32'h3100; e_be = 4'hF;
        @(negedge clk); #1;
        chk_en = 0;
        reset = 1; drop_inputs();
        #1;
        check("rst_async_req", 32'(mem_req), 32'd0);
        check("rst_async_stall", 32'(stall), 32'd0);
        exp_idle();
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk); #1;
        check("rst_no_completion", rdata, 32'h0);
        $display("[TB] reset during access: mem_req=%0d stall=%0d after release", mem_req, stall);

        access("lh_after_reset", 0, 1, 2'b00, 2'b01, 0, 32'h5002, 32'h0, 1, 32'h7FFF_0000, 0);
        check("lh_rst_rdata", o_rdata, 32'h0000_7FFF);
        check("lh_rst_be", 32'(o_be), 32'hC);

        @(posedge clk); #1;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit directly downstream of instruction decode in the RV32I core.
- Consumes d_wr_en, store_size and load_size from decode, plus the ALU-computed address and the rs2 store data.
- Drives a word-addressed data RAM port with byte enables and a req/ack handshake, so RAM may take several cycles.
- Stalls the core while an access is outstanding and returns sign- or zero-extended load data for the register-file write-back mux.

Parameters:
- TIMEOUT, 16: max cycles waiting for mem_ack before abort (>=2).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- d_wr_en  in  1  store request (S-type)
- d_rd_en  in  1  load request (IL-type)
- store_size  in  2  00 sb, 01 sh, 10 sw; 11 treated as sw
- load_size  in  2  00 lb, 01 lh, 10 lw; 11 treated as lw
- load_unsigned  in  1  funct3[2]; 1 = lbu/lhu zero-extend
- addr  in  ADDR_W  byte address from ALU
- wdata  in  32  rs2 store data, right-aligned
- rdata  out  32  extended load result
- stall  out  1  hold PC and register write
- misaligned  out  1  one-cycle pulse on misaligned access
- bus_err  out  1  one-cycle pulse on timeout
- mem_req  out  1  RAM request
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W  word address ({addr[ADDR_W-1:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_ack  in  1  RAM completion, single-cycle pulse
- mem_rdata  in  32  RAM read word, valid with mem_ack

Behaviour:
- Reset: all outputs 0; FSM=IDLE; timeout counter 0. Reset asserted mid-access drops mem_req at once; no completion is reported.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, request present (d_wr_en|d_rd_en), aligned:
  - Register the request and go to ACCESS.
  - stall is combinationally 1 in that same cycle.
  - If both enables are set, the store wins (mem_we=1).
- Alignment rule: sh/lh needs addr[0]=0; sw/lw needs addr[1:0]=00. Byte accesses are always aligned.
- IDLE, misaligned request: no memory access; misaligned=1 for that cycle; stall=0; rdata=0.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_be and mem_wdata are held stable from registered values.
  - stall=1.
  - The counter increments every cycle.
- mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- ACCESS exit on mem_ack:
  - Capture mem_rdata, go to DONE, clear the counter.
  - A mem_ack in IDLE or DONE is ignored.
- ACCESS exit on timeout: when the counter reaches TIMEOUT-1 with no ack, go to DONE with bus_err=1 in DONE and captured data 0.
- DONE:
  - stall=0 and rdata is valid for exactly one cycle, so the core retires the instruction at that edge.
  - Next state is IDLE. DONE does not sample new requests, so the same instruction is never reissued.
- Load extraction, using the registered addr[1:0]:
  - Byte = mem_rdata[8*addr[1:0]+:8].
  - Half = mem_rdata[16*addr[1]+:16].
  - Extend by load_unsigned: sign-extend when 0, zero-extend when 1.
  - Word passes through.
  - For stores, rdata=0 in DONE.
- Access latency: 1 (IDLE) + N (ACCESS until ack) + 1 (DONE) cycles. With ack in the first ACCESS cycle the total is 3 cycles, with stall high for 2.

Test Plan:
- Store sb: addr=0x1003, wdata=0xAB, ack after 1 cycle -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000; stall high 2 cycles.
- Load lb: addr=0x2002, mem_rdata=0x00800000, load_unsigned=0 -> rdata=0xFFFFFF80. Same access with load_unsigned=1 -> rdata=0x00000080.
- Load lw: addr=0x3000, ack delayed 5 cycles, mem_rdata=0xDEADBEEF -> stall held 6 cycles, rdata=0xDEADBEEF in DONE only, mem_req stable throughout.
- Misaligned sw: addr=0x4002 -> misaligned pulse, mem_req never asserted, stall=0.
- Timeout: TIMEOUT=16, no ack -> bus_err in the cycle after 16 ACCESS cycles, rdata=0, return to IDLE. A late ack afterwards is ignored.
- Reset asserted in ACCESS -> mem_req=0 asynchronously, FSM=IDLE. After release, a new lh at 0x5002 with mem_rdata=0x7FFF0000 completes with rdata=0x00007FFF.
